// File: rtl/snn_decoder_pkg.sv
// Shared constants and output-register state type for the spike-rate decoder.
package snn_decoder_pkg;

    localparam int unsigned DEF_NUM_CH     = 2;
    localparam int unsigned DEF_WIN        = 64;
    localparam int unsigned DEF_CNT_W      = 8;
    localparam int unsigned DEF_MIN_SPIKES = 4;

    typedef enum logic {
        DEC_EMPTY = 1'b0,
        DEC_FULL  = 1'b1
    } dec_state_e;

endpackage

// File: rtl/spike_counter.sv
// Per-channel saturating spike counter; cnt_inc is the count including this cycle's spike.
module spike_counter
    import snn_decoder_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_inc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sat;

    always_comb begin
        sat     = &cnt_q;
        cnt_inc = cnt_q;
        if (en && inc && !sat) begin
            cnt_inc = cnt_q + CNT_W'(1);
        end
        // clr marks the closing cycle: its spike is reported via cnt_inc, then dropped
        cnt_d = clr ? '0 : cnt_inc;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed spike-rate decoder with argmax winner and valid/ready output register.
// Tie behaviour: define SPIKE_RATE_DECODER_TIE_HOLD_EN to repeat the last non-tie decision.
module spike_rate_decoder
    import snn_decoder_pkg::*;
#(
    parameter int unsigned NUM_CH     = DEF_NUM_CH,
    parameter int unsigned WIN        = DEF_WIN,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned MIN_SPIKES = DEF_MIN_SPIKES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_CH-1:0]         spike_in,
    output logic                      dec_valid,
    input  logic                      dec_ready,
    output logic                      dec_hit,
    output logic [$clog2(NUM_CH)-1:0] dec_idx,
    output logic [CNT_W-1:0]          dec_count,
    output logic                      ovr,
    input  logic                      clr_ovr
);

    localparam int unsigned      WIN_W    = $clog2(WIN);
    localparam int unsigned      IDX_W    = $clog2(NUM_CH);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN - 1);

    logic [WIN_W-1:0] win_q, win_d;
    logic             win_end;

    logic [CNT_W-1:0] cnt_inc [NUM_CH];
    logic [CNT_W-1:0] max_cnt;
    logic [IDX_W-1:0] max_idx;
    logic             tie;
    logic             below;
    logic             res_hit;
    logic [IDX_W-1:0] res_idx;

    dec_state_e       state_q, state_d;
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovr_q, ovr_d;

    always_comb begin
        win_end = en && (win_q == WIN_LAST);
        win_d   = win_q;
        if (win_end) begin
            win_d = '0;
        end else if (en) begin
            win_d = win_q + WIN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        spike_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .inc     (spike_in[g]),
            .clr     (win_end),
            .cnt_inc (cnt_inc[g])
        );
    end

    // Lowest index wins the running max; any later equal count flags a tie on that max.
    always_comb begin
        max_cnt = cnt_inc[0];
        max_idx = '0;
        tie     = 1'b0;
        for (int unsigned i = 1; i < NUM_CH; i++) begin
            if (cnt_inc[i] > max_cnt) begin
                max_cnt = cnt_inc[i];
                max_idx = IDX_W'(i);
                tie     = 1'b0;
            end else if (cnt_inc[i] == max_cnt) begin
                tie = 1'b1;
            end
        end
        below = 32'(max_cnt) < MIN_SPIKES;
    end

`ifdef SPIKE_RATE_DECODER_TIE_HOLD_EN
    logic             held_hit_q, held_hit_d;
    logic [IDX_W-1:0] held_idx_q, held_idx_d;

    always_comb begin
        res_hit = 1'b0;
        res_idx = '0;
        if (!below && !tie) begin
            res_hit = 1'b1;
            res_idx = max_idx;
        end else if (!below) begin
            res_hit = held_hit_q;
            res_idx = held_idx_q;
        end
        // Below-threshold results count as decisions and overwrite the held one
        held_hit_d = held_hit_q;
        held_idx_d = held_idx_q;
        if (win_end && (below || !tie)) begin
            held_hit_d = res_hit;
            held_idx_d = res_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            held_hit_q <= 1'b0;
            held_idx_q <= '0;
        end else begin
            held_hit_q <= held_hit_d;
            held_idx_q <= held_idx_d;
        end
    end
`else
    always_comb begin
        res_hit = 1'b0;
        res_idx = '0;
        if (!below && !tie) begin
            res_hit = 1'b1;
            res_idx = max_idx;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        hit_d   = hit_q;
        idx_d   = idx_q;
        count_d = count_q;
        ovr_d   = ovr_q;
        if (clr_ovr) begin
            ovr_d = 1'b0;
        end
        unique case (state_q)
            DEC_EMPTY: begin
                if (win_end) begin
                    state_d = DEC_FULL;
                end
            end
            DEC_FULL: begin
                // A new result replaces the pending one; it is an overrun only if not taken
                if (win_end) begin
                    if (!dec_ready) begin
                        ovr_d = 1'b1;
                    end
                end else if (dec_ready) begin
                    state_d = DEC_EMPTY;
                end
            end
        endcase
        if (win_end) begin
            hit_d   = res_hit;
            idx_d   = res_idx;
            count_d = max_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= DEC_EMPTY;
            hit_q   <= 1'b0;
            idx_q   <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dec_valid = (state_q == DEC_FULL);
    assign dec_hit   = hit_q;
    assign dec_idx   = idx_q;
    assign dec_count = count_q;
    assign ovr       = ovr_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: table of windows checked via scoreboard, plus corner sequences.
module tb_spike_rate_decoder;

    localparam int WIN = 64;
`ifdef SPIKE_RATE_DECODER_TIE_HOLD_EN
    localparam int TH = 1;
`else
    localparam int TH = 0;
`endif

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       en        = 1'b0;
    logic       dec_ready = 1'b0;
    logic       clr_ovr   = 1'b0;
    logic [1:0] spike_in  = 2'b00;

    logic       dec_valid, dec_hit, ovr;
    logic [0:0] dec_idx;
    logic [7:0] dec_count;
    logic       s_valid, s_hit, s_ovr;
    logic [0:0] s_idx;
    logic [4:0] s_count;

    int n_vec = 0;
    int n_bad = 0;
    bit mon_on = 1'b0;

    typedef struct { int hit; int idx; int cnt; } exp_t;
    typedef struct { int p0; int p1; int hit; int idx; int cnt; } vec_t;
    exp_t sb_q[$];
    vec_t vecs [10];

    always #5 clk = ~clk;

    spike_rate_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .spike_in  (spike_in),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .dec_hit   (dec_hit),
        .dec_idx   (dec_idx),
        .dec_count (dec_count),
        .ovr       (ovr),
        .clr_ovr   (clr_ovr)
    );

    spike_rate_decoder #(
        .CNT_W (5)
    ) dut_s (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .spike_in  (spike_in),
        .dec_valid (s_valid),
        .dec_ready (dec_ready),
        .dec_hit   (s_hit),
        .dec_idx   (s_idx),
        .dec_count (s_count),
        .ovr       (s_ovr),
        .clr_ovr   (clr_ovr)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic e, input logic [1:0] sp);
        en       = e;
        spike_in = sp;
        @(posedge clk);
        #1;
    endtask

    // Channel i spikes on window cycles c where c % p_i == 0 (p_i == 0: never).
    function automatic logic [1:0] pat(input int p0, input int p1, input int c);
        logic [1:0] s;
        s[0] = (p0 != 0) && ((c % p0) == 0);
        s[1] = (p1 != 0) && ((c % p1) == 0);
        return s;
    endfunction

    task automatic run_window(input int p0, input int p1);
        for (int c = 0; c < WIN; c++) step(1'b1, pat(p0, p1, c));
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        dec_ready = 1'b0;
        clr_ovr   = 1'b0;
        step(1'b1, 2'b11);
        rst = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_on && dec_valid && dec_ready) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got a decision, expected none (t=%0t)", $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_hit", int'(dec_hit), e.hit);
                    chk("sb_idx", int'(dec_idx), e.idx);
                    chk("sb_count", int'(dec_count), e.cnt);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        int   cyc;
        bit   found;
        exp_t e;

        vecs[0] = '{4, 8, 1, 0, 16};
        vecs[1] = '{8, 4, 1, 1, 16};
        vecs[2] = '{7, 7, TH, TH, 10};
        vecs[3] = '{0, 22, 0, 0, 3};
        vecs[4] = '{7, 7, 0, 0, 10};
        vecs[5] = '{16, 0, 1, 0, 4};
        vecs[6] = '{0, 17, 1, 1, 4};
        vecs[7] = '{7, 7, TH, TH, 10};
        vecs[8] = '{1, 2, 1, 0, 64};
        vecs[9] = '{0, 0, 0, 0, 0};

        // Reset with toggling spikes, then latency of the first window
        rst       = 1'b0;
        dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, (i % 2 == 0) ? 2'b11 : 2'b00);
        chk("rst_valid", int'(dec_valid), 0);
        chk("rst_hit", int'(dec_hit), 0);
        chk("rst_idx", int'(dec_idx), 0);
        chk("rst_count", int'(dec_count), 0);
        chk("rst_ovr", int'(ovr), 0);
        rst   = 1'b1;
        cyc   = 1;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            step(1'b1, 2'b00);
            cyc++;
            if (dec_valid) found = 1'b1;
        end
        chk("first_valid_cycle", found ? cyc : -1, 65);
        chk("first_count", int'(dec_count), 0);

        // Back-to-back windows through the scoreboard
        do_reset();
        dec_ready = 1'b1;
        mon_on    = 1'b1;
        for (int v = 0; v < 10; v++) begin
            for (int c = 0; c < WIN; c++) begin
                if (c == WIN - 1) begin
                    e.hit = vecs[v].hit;
                    e.idx = vecs[v].idx;
                    e.cnt = vecs[v].cnt;
                    sb_q.push_back(e);
                end
                step(1'b1, pat(vecs[v].p0, vecs[v].p1, c));
            end
        end
        step(1'b0, 2'b00);
        chk("valid_pulse_1cyc", int'(dec_valid), 0);
        step(1'b0, 2'b00);
        mon_on = 1'b0;
        chk("sb_drain", sb_q.size(), 0);

        // Overrun, clear, clear colliding with overrun, accept colliding with load
        do_reset();
        run_window(13, 0);
        chk("ovr_first_valid", int'(dec_valid), 1);
        chk("ovr_first_count", int'(dec_count), 5);
        chk("ovr_first_flag", int'(ovr), 0);
        run_window(0, 10);
        chk("ovr_set", int'(ovr), 1);
        chk("ovr_valid", int'(dec_valid), 1);
        chk("ovr_hit", int'(dec_hit), 1);
        chk("ovr_idx", int'(dec_idx), 1);
        chk("ovr_count", int'(dec_count), 7);
        clr_ovr = 1'b1;
        step(1'b1, 2'b00);
        clr_ovr = 1'b0;
        chk("ovr_cleared", int'(ovr), 0);
        chk("ovr_still_pending", int'(dec_valid), 1);
        for (int c = 1; c < WIN; c++) begin
            if (c == WIN - 1) clr_ovr = 1'b1;
            step(1'b1, 2'b00);
        end
        clr_ovr = 1'b0;
        chk("clr_vs_overrun", int'(ovr), 1);
        chk("clr_vs_overrun_count", int'(dec_count), 0);
        clr_ovr = 1'b1;
        step(1'b1, 2'b00);
        clr_ovr = 1'b0;
        for (int c = 1; c < WIN; c++) begin
            if (c == WIN - 1) dec_ready = 1'b1;
            step(1'b1, pat(0, 10, c));
        end
        chk("accept_load_valid", int'(dec_valid), 1);
        chk("accept_load_ovr", int'(ovr), 0);
        chk("accept_load_idx", int'(dec_idx), 1);
        chk("accept_load_count", int'(dec_count), 6);
        step(1'b0, 2'b00);
        chk("accept_drop_valid", int'(dec_valid), 0);

        // Enable gating: 20 idle cycles mid-window with all spikes asserted
        do_reset();
        for (int c = 0; c < 30; c++) step(1'b1, pat(8, 0, c));
        for (int c = 0; c < 20; c++) step(1'b0, 2'b11);
        for (int c = 30; c < WIN; c++) begin
            if (c == WIN - 1) chk("gate_not_early", int'(dec_valid), 0);
            step(1'b1, pat(8, 0, c));
        end
        chk("gate_valid", int'(dec_valid), 1);
        chk("gate_count", int'(dec_count), 8);
        chk("gate_hit", int'(dec_hit), 1);

        // Saturation in the 5-bit instance
        do_reset();
        run_window(1, 0);
        chk("sat_count5", int'(s_count), 31);
        chk("sat_hit5", int'(s_hit), 1);
        chk("sat_idx5", int'(s_idx), 0);
        chk("sat_count8", int'(dec_count), 64);

        // Reset mid-window while a decision is pending
        for (int c = 0; c < 30; c++) step(1'b1, 2'b10);
        rst = 1'b0;
        step(1'b1, 2'b10);
        rst = 1'b1;
        chk("midrst_valid", int'(dec_valid), 0);
        chk("midrst_count", int'(dec_count), 0);
        chk("midrst_hit", int'(dec_hit), 0);
        for (int c = 0; c < WIN; c++) begin
            if (c == WIN - 1) chk("midrst_not_early", int'(dec_valid), 0);
            step(1'b1, pat(16, 0, c));
        end
        chk("midrst_new_valid", int'(dec_valid), 1);
        chk("midrst_new_hit", int'(dec_hit), 1);
        chk("midrst_new_idx", int'(dec_idx), 0);
        chk("midrst_new_count", int'(dec_count), 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Rate decoder for the excitatory-layer output spike trains; the inverse of the input neurons' sensor-to-spike encoding. It counts spikes per output neuron over a fixed window of enabled cycles. At each window end it selects the winning channel, for example Left/Right steering. It then presents the decision to the motor/control logic through a valid/ready handshake.

## Interface
Parameters:
- NUM_CH, 2: number of spike channels (one per excitatory neuron).
- WIN, 64: window length in enabled cycles (≥2).
- CNT_W, 8: per-channel counter width; counters saturate.
- MIN_SPIKES, 4: minimum winning count for a valid hit.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- en  in  1  global enable; low freezes the window counter and spike counters.
- spike_in  in  NUM_CH  output spikes of the excitatory neurons, one bit per channel.
- dec_valid  out  1  decision pending.
- dec_ready  in  1  consumer accepts the decision.
- dec_hit  out  1  1 = a winner exists; 0 = no decision.
- dec_idx  out  $clog2(NUM_CH)  index of the winning channel.
- dec_count  out  CNT_W  spike count of the winning channel.
- ovr  out  1  sticky overrun flag.
- clr_ovr  in  1  clears ovr.

## Operation
- Window counter: runs 0..WIN-1 and increments only when en=1.
- Spike counting: on an en cycle, each channel counter adds 1 if spike_in[i]=1.
  - Counters saturate at 2^CNT_W-1.
- Window end: the en cycle with window counter = WIN-1.
  - Spikes on that cycle are included in the closing window.
  - All counters and the window counter restart at 0 on the following cycle, so spikes on the first cycle of the next window count in the next window.
- Winner evaluation, on the closed counts:
  - max = the largest count.
  - If max < MIN_SPIKES: dec_hit=0, dec_idx=0.
  - Else, if exactly one channel equals max: dec_hit=1, dec_idx=that channel.
  - Else (tie on max): behaviour set by the macro (see Configuration).
  - dec_count is always max, saturated.
- Output register FSM, two states:
  - EMPTY to FULL on a window end.
  - FULL to EMPTY on dec_valid && dec_ready with no simultaneous new result.
- Overrun: a window-end result arriving while FULL and not being accepted that cycle overwrites the pending result and sets ovr.
  - If acceptance and a new result coincide, the new result is loaded, the state stays FULL, and ovr is not set.
- clr_ovr clears ovr. If clr_ovr and a new overrun coincide, ovr ends at 1.
- en=0 has no effect on the handshake; dec_valid/dec_ready continue to operate.

## Timing
- Reset (rst=0 at a clock edge) forces:
  - dec_valid=0, dec_hit=0, dec_idx=0, dec_count=0, ovr=0;
  - all counters and the window counter to 0;
  - FSM state EMPTY;
  - the held-decision register (macro build) to hit=0, idx=0.
- Reset mid-window discards the partial counts; the first window after reset is a full WIN en-cycles.
- Latency: dec_valid rises one cycle after the window-end cycle. Outputs are registered.
- Handshake:
  - dec_hit, dec_idx and dec_count are stable while dec_valid=1 and no new window ends.
  - Transfer occurs on a cycle with dec_valid=1 and dec_ready=1.
  - dec_valid falls the next cycle unless a new result is loaded.
  - dec_ready asserted while dec_valid=0 has no effect.

## Configuration
- SPIKE_RATE_DECODER_TIE_HOLD_EN defined:
  - On a tie, dec_hit and dec_idx repeat the last non-tie decision.
  - The last non-tie decision includes below-threshold results (hit=0).
  - Requires a held-decision register.
- Not defined: a tie gives dec_hit=0, dec_idx=0.
- dec_count = max in both builds.

## Structure
- Shared package snn_decoder_pkg holds:
  - the default WIN/CNT_W/MIN_SPIKES constants;
  - the output FSM state enum (DEC_EMPTY, DEC_FULL).
- Sub-module spike_counter: one per channel, a CNT_W saturating counter with inc, clr and en inputs.
- The top module holds the window counter, the argmax/tie logic, the output FSM and ovr.

## Test plan
- Reset: hold rst=0 for 3 cycles with spikes toggling → all outputs 0; first dec_valid arrives exactly 65 cycles after rst rises (en=1 continuous).
- Clear winner: ch0 spikes every 4th cycle (16), ch1 every 8th (8), dec_ready=1 → dec_valid pulse for 1 cycle with hit=1, idx=0, count=16.
- Threshold and tie:
  - ch1 3 spikes, ch0 0 → hit=0, count=3.
  - Both channels 10 spikes → hit=0, idx=0 (macro off); with macro, after a prior idx=1 win → hit=1, idx=1.
- Overrun: dec_ready=0 across two windows (ch0=5 then ch1=7) → ovr=1; pending result hit=1, idx=1, count=7; clr_ovr pulse → ovr=0.
- Enable gating and saturation:
  - en low for 20 cycles mid-window → window end delayed by 20 cycles; spikes during en=0 not counted.
  - CNT_W=5, ch0 spiking every cycle → count=31.
- Reset mid-window: rst=0 at window cycle 30 with dec_valid=1 → dec_valid=0 next cycle; next result reflects only post-reset spikes.
